// File: rtl/funnel_unpacker.sv
// Bit-funnel unpacker: buffers an MSB-first byte stream in a 16-bit window and
// extracts 1..8-bit fields, zero- or sign-extended, with a one-cycle latency.
module funnel_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] req_len,
    input  logic       req_signed,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    input  logic       flush,
    output logic [4:0] level
);

    logic [15:0] r_buf;
    logic [4:0]  r_level;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic        r_err;

    logic        w_len_legal;
    logic        w_in_ready;
    logic        w_req_ready;
    logic        w_byte_acc;
    logic        w_req_acc;
    logic        w_take;
    logic [4:0]  w_shift;
    logic [4:0]  w_rem_level;
    logic [15:0] w_shifted;
    logic [15:0] w_insert;
    logic [3:0]  w_field_shift;
    logic [7:0]  w_field;
    logic [7:0]  w_fill;
    logic [7:0]  w_extracted;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        w_len_legal   = (req_len != 4'd0) && (req_len <= 4'd8);
        w_in_ready    = (r_level <= 5'd8) && !flush;
        w_req_ready   = !flush && (!r_out_valid || out_ready) &&
                        (!w_len_legal || (r_level >= {1'b0, req_len}));
        w_byte_acc    = in_valid && w_in_ready;
        w_req_acc     = req_valid && w_req_ready;
        w_take        = w_req_acc && w_len_legal;
        w_shift       = w_take ? {1'b0, req_len} : 5'd0;
        w_rem_level   = r_level - w_shift;
        w_shifted     = r_buf << w_shift;
        // New byte lands directly below the bits that survive this cycle's consume.
        w_insert      = {in_data, 8'h00} >> w_rem_level;
        w_field_shift = 4'd8 - req_len;
        w_field       = r_buf[15:8] >> w_field_shift;
        w_fill        = (req_signed && r_buf[15]) ? (8'hFF << req_len) : 8'h00;
        w_extracted   = w_field | w_fill;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf       <= 16'h0000;
            r_level     <= 5'd0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_req_acc && !w_len_legal;

            if (flush) begin
                r_buf   <= 16'h0000;
                r_level <= 5'd0;
            end else begin
                r_buf   <= w_byte_acc ? (w_shifted | w_insert) : w_shifted;
                r_level <= w_rem_level + (w_byte_acc ? 5'd8 : 5'd0);
            end

            if (w_take) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_extracted;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign req_ready = w_req_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign level     = r_level;

endmodule

// File: tb/tb_funnel_unpacker.sv
// Self-checking bench for funnel_unpacker: a bit-queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_funnel_unpacker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] req_len = 4'd1;
    logic       req_signed = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err;
    logic       flush = 1'b0;
    logic [4:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    funnel_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .req_len    (req_len),
        .req_signed (req_signed),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err        (err),
        .flush      (flush),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a queue of buffered bits ----------------
    bit         m_q[$];
    logic       m_ov  = 1'b0;
    logic [7:0] m_od  = 8'h00;
    logic       m_err = 1'b0;
    logic       m_ar, m_ab, m_sign;
    logic [7:0] m_v, m_mask;

    function automatic logic legal(input logic [3:0] l);
        return (l >= 4'd1) && (l <= 4'd8);
    endfunction

    function automatic logic exp_in_ready();
        return (m_q.size() <= 8) && !flush;
    endfunction

    function automatic logic exp_req_ready();
        return !flush && (!m_ov || out_ready) && (!legal(req_len) || (m_q.size() >= int'(req_len)));
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_ov  = 1'b0;
            m_od  = 8'h00;
            m_err = 1'b0;
        end else begin
            m_ar  = req_valid && exp_req_ready();
            m_ab  = in_valid && exp_in_ready();
            m_err = m_ar && !legal(req_len);
            if (m_ar && legal(req_len)) begin
                m_v    = 8'h00;
                m_sign = m_q[0];
                for (int i = 0; i < int'(req_len); i++) m_v = {m_v[6:0], m_q.pop_front()};
                if (req_signed && m_sign) begin
                    m_mask = 8'hFF;
                    m_mask = m_mask << req_len;
                    m_v    = m_v | m_mask;
                end
                m_od = m_v;
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            if (flush) m_q.delete();
            else if (m_ab) for (int i = 7; i >= 0; i--) m_q.push_back(in_data[i]);
        end
    end

    always @(negedge clk) begin
        check("level",     32'(level),     m_q.size());
        check("in_ready",  32'(in_ready),  32'(exp_in_ready()));
        check("req_ready", 32'(req_ready), 32'(exp_req_ready()));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data",  32'(out_data),  32'(m_od));
        check("err",       32'(err),       32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        logic ok = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        check("byte_accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_req(input logic [3:0] len, input logic sgn);
        logic ok = 1'b0;
        req_len    = len;
        req_signed = sgn;
        req_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("req_accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level",     32'(level),     0);
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Stream: 0xB4, 0x5C then unsigned 3,5,4,4
        send_byte(8'hB4);
        send_byte(8'h5C);
        check("stream_level16", 32'(level), 16);
        do_req(4'd3, 1'b0); check("stream_f0", 32'(out_data), 32'h05);
        do_req(4'd5, 1'b0); check("stream_f1", 32'(out_data), 32'h14);
        do_req(4'd4, 1'b0); check("stream_f2", 32'(out_data), 32'h05);
        do_req(4'd4, 1'b0); check("stream_f3", 32'(out_data), 32'h0C);
        check("stream_level0", 32'(level), 0);

        // Sign extension
        send_byte(8'hE0);
        do_req(4'd3, 1'b1); check("sign_neg", 32'(out_data), 32'hFF);
        do_req(4'd5, 1'b1); check("sign_pos", 32'(out_data), 32'h00);
        req_len = 4'd1; req_signed = 1'b0; req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("starved_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Simultaneous byte accept and 8-bit consume at level 8
        send_byte(8'hA5);
        in_data = 8'h3C; in_valid = 1'b1;
        req_len = 4'd8; req_signed = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        check("simul_in_ready",  32'(in_ready),  1);
        check("simul_req_ready", 32'(req_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; req_valid = 1'b0;
        check("simul_data",  32'(out_data), 32'hA5);
        check("simul_level", 32'(level), 8);
        do_req(4'd4, 1'b0); check("simul_next", 32'(out_data), 32'h03);
        do_req(4'd4, 1'b0); check("simul_tail", 32'(out_data), 32'h0C);

        // Back-pressure and illegal lengths
        send_byte(8'h96);
        send_byte(8'h0F);
        out_ready = 1'b0;
        do_req(4'd4, 1'b0); check("bp_data", 32'(out_data), 32'h09);
        req_len = 4'd4; req_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_hold_data", 32'(out_data),  32'h09);
            check("bp_hold_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", 32'(out_valid), 0);
        do_req(4'd0, 1'b0);
        check("err_len0", 32'(err), 1);
        check("err_len0_level", 32'(level), 12);
        check("err_len0_noout", 32'(out_valid), 0);
        @(posedge clk); #1;
        check("err_pulse_end", 32'(err), 0);
        do_req(4'd9, 1'b0);
        check("err_len9", 32'(err), 1);
        check("err_len9_level", 32'(level), 12);
        do_req(4'd8, 1'b0); check("bp_rest8", 32'(out_data), 32'h60);
        do_req(4'd4, 1'b0); check("bp_rest4", 32'(out_data), 32'h0F);
        check("bp_level0", 32'(level), 0);

        // Flush with a pending output and a concurrent byte
        send_byte(8'hF2);
        send_byte(8'h34);
        out_ready = 1'b0;
        do_req(4'd3, 1'b0);
        check("flush_pre_data",  32'(out_data), 32'h07);
        check("flush_pre_level", 32'(level), 13);
        flush = 1'b1; in_data = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready",  32'(in_ready),  0);
        check("flush_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_level",     32'(level),     0);
        check("flush_out_valid", 32'(out_valid), 1);
        check("flush_out_data",  32'(out_data),  32'h07);
        @(negedge clk);
        check("flush_no_byte", 32'(level), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with level 11 and a pending output
        send_byte(8'hAB);
        send_byte(8'hCD);
        out_ready = 1'b0;
        do_req(4'd5, 1'b0);
        check("mid_data",  32'(out_data), 32'h15);
        check("mid_level", 32'(level), 11);
        req_len = 4'd5;
        #2 rst = 1'b1;
        #1;
        check("arst_level",     32'(level),     0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_data",  32'(out_data),  0);
        check("arst_in_ready",  32'(in_ready),  1);
        check("arst_req_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
